// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC bus scheduler: FSM states, active-low
// strobe vectors {CS, AD, RD, WR} and the RTC register map used by the requesters.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP,
    ST_DATA,
    ST_REC
  } state_t;

  localparam logic [3:0] CTRL_IDLE   = 4'b1111;
  localparam logic [3:0] CTRL_ADDR_W = 4'b0010;
  localparam logic [3:0] CTRL_CS     = 4'b0111;
  localparam logic [3:0] CTRL_WR     = 4'b0110;
  localparam logic [3:0] CTRL_RD     = 4'b0101;

  localparam logic [7:0] RTC_REG_SEC   = 8'h20;
  localparam logic [7:0] RTC_REG_MIN   = 8'h21;
  localparam logic [7:0] RTC_REG_HOUR  = 8'h22;
  localparam logic [7:0] RTC_REG_DAY   = 8'h23;
  localparam logic [7:0] RTC_REG_DATE  = 8'h24;
  localparam logic [7:0] RTC_REG_MONTH = 8'h25;
  localparam logic [7:0] RTC_REG_YEAR  = 8'h26;
  localparam logic [7:0] RTC_REG_CTRL  = 8'h2F;

endpackage

// File: rtl/rtc_bus_sched_if.sv
// Requester and pad-side signals of the RTC bus scheduler; slave is the scheduler,
// master is whoever drives requests and models the AD pads.
interface rtc_bus_sched_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   we;
  logic [8*N_REQ-1:0] addr;
  logic [8*N_REQ-1:0] wdata;
  logic [N_REQ-1:0]   done;
  logic [7:0]         rdata;
  logic               busy;
  logic [3:0]         control;
  logic [7:0]         ad_out;
  logic               ad_oe;
  logic [7:0]         ad_in;

  modport master (
    output req, we, addr, wdata, ad_in,
    input  done, rdata, busy, control, ad_out, ad_oe
  );

  modport slave (
    input  req, we, addr, wdata, ad_in,
    output done, rdata, busy, control, ad_out, ad_oe
  );
endinterface

// File: rtl/rtc_rr_arb.sv
// Combinational grant: requester 0 has absolute priority, the rest are round-robin
// starting at ptr; ptr advances past the winner only when the grant is consumed (en).
module rtc_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic             gnt_vld,
  output logic [IW-1:0]    gnt_idx
);

  logic [IW-1:0] ptr;
  logic          hit_hi;
  logic          hit_lo;
  logic [IW-1:0] idx_hi;
  logic [IW-1:0] idx_lo;

  // Search at-or-above the pointer first, then wrap to the indices below it.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = 1; i < N_REQ; i++) begin
      if (!hit_hi && req[i] && (IW'(i) >= ptr)) begin
        hit_hi = 1'b1;
        idx_hi = IW'(i);
      end
      if (!hit_lo && req[i] && (IW'(i) < ptr)) begin
        hit_lo = 1'b1;
        idx_lo = IW'(i);
      end
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (req[0]) begin
      gnt_vld = 1'b1;
    end else if (hit_hi) begin
      gnt_vld = 1'b1;
      gnt_idx = idx_hi;
    end else if (hit_lo) begin
      gnt_vld = 1'b1;
      gnt_idx = idx_lo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= IW'(1);
    end else if (en && gnt_vld && (gnt_idx != '0)) begin
      ptr <= (gnt_idx == IW'(N_REQ - 1)) ? IW'(1) : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/rtc_bus_sched.sv
// Runs one granted request as a full address/gap/data/recovery cycle on the RTC bus;
// new grants are taken only in IDLE, all pad outputs and done/busy are registered.
module rtc_bus_sched
  import rtc_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int T_ADDR = 4,
  parameter int T_GAP  = 2,
  parameter int T_DATA = 6,
  parameter int T_REC  = 2
) (
  input  logic           clk,
  input  logic           reset,
  rtc_bus_sched_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  logic [7:0]       cnt;
  logic [IW-1:0]    owner;
  logic             lat_we;
  logic [7:0]       lat_wdata;
  logic [N_REQ-1:0] done_q;
  logic [7:0]       rdata_q;
  logic             busy_q;
  logic [3:0]       control_q;
  logic [7:0]       ad_out_q;
  logic             ad_oe_q;

  logic             gnt_vld;
  logic [IW-1:0]    gnt_idx;
  logic [7:0]       sel_addr;
  logic [7:0]       sel_wdata;
  logic             sel_we;

  rtc_rr_arb #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.req),
    .en      (state == ST_IDLE),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_addr  = bus.addr[8*i +: 8];
        sel_wdata = bus.wdata[8*i +: 8];
        sel_we    = bus.we[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      owner     <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      control_q <= CTRL_IDLE;
      ad_out_q  <= '0;
      ad_oe_q   <= 1'b0;
    end else begin
      done_q <= '0;
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            owner     <= gnt_idx;
            lat_we    <= sel_we;
            lat_wdata <= sel_wdata;
            busy_q    <= 1'b1;
            control_q <= CTRL_ADDR_W;
            ad_oe_q   <= 1'b1;
            ad_out_q  <= sel_addr;
            cnt       <= 8'(T_ADDR - 1);
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (cnt == '0) begin
            control_q <= CTRL_CS;
            ad_oe_q   <= 1'b0;
            ad_out_q  <= '0;
            cnt       <= 8'(T_GAP - 1);
            state     <= ST_GAP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            control_q <= lat_we ? CTRL_WR : CTRL_RD;
            ad_oe_q   <= lat_we;
            ad_out_q  <= lat_we ? lat_wdata : 8'h00;
            cnt       <= 8'(T_DATA - 1);
            state     <= ST_DATA;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            // The pads still show the read data during this last DATA cycle.
            if (!lat_we) begin
              rdata_q <= bus.ad_in;
            end
            done_q[owner] <= 1'b1;
            control_q     <= CTRL_IDLE;
            ad_oe_q       <= 1'b0;
            ad_out_q      <= '0;
            cnt           <= 8'(T_REC - 1);
            state         <= ST_REC;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_REC: begin
          if (cnt == '0) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.done    = done_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = busy_q;
  assign bus.control = control_q;
  assign bus.ad_out  = ad_out_q;
  assign bus.ad_oe   = ad_oe_q;

endmodule

// File: doc/rtc_bus_sched.md
# rtc_bus_sched

Schedules and executes transactions on the shared multiplexed RTC address/data bus (CS/AD/RD/WR strobes plus 8-bit AD lines). Up to four requesters share the bus through one arbiter: the init sequence, date edit, time edit and timer edit. Each granted request becomes one complete address-phase/data-phase bus cycle. The block sits between the per-function controllers and the RTC pads, so exactly one agent drives the bus at any time.

## Interface
- N_REQ, 4: number of requesters. Index 0 is init, 1 is date, 2 is time, 3 is timer.
- T_ADDR, 4: cycles in the address phase.
- T_GAP, 2: cycles between the address and data phases.
- T_DATA, 6: cycles in the data phase.
- T_REC, 2: recovery cycles after the data phase, with all strobes deasserted.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  request level, one bit per requester.
- we  in  N_REQ  1 = write, 0 = read, per requester.
- addr  in  8*N_REQ  RTC register address; requester i occupies bits [8i+7:8i].
- wdata  in  8*N_REQ  write data, packed the same way.
- done  out  N_REQ  one-cycle pulse to the owning requester when its transaction ends.
- rdata  out  8  read data; valid in the cycle done pulses and held until the next read.
- busy  out  1  high from grant until the end of recovery.
- control  out  4  bit 3 CS, bit 2 AD, bit 1 RD, bit 0 WR; all active-low.
- ad_out  out  8  value driven on the AD pads.
- ad_oe  out  1  pad output enable; 1 = drive.
- ad_in  in  8  value sampled from the AD pads.

## Operation
- States: IDLE, ADDR, GAP, DATA, REC. A phase counter counts down within each state.
- IDLE:
  - control = 1111, ad_oe = 0, ad_out = 0.
  - If any req bit is set, grant one requester, latch its we, addr and wdata, then go to ADDR.
- Arbitration:
  - Requester 0 (init) has absolute priority.
  - Requesters 1–3 are served round-robin. The pointer starts just after the last granted index in 1–3 and resets to 1.
  - The winner is recorded in an owner register.
- ADDR, for T_ADDR cycles: control = 0010 (CS, AD, WR asserted), ad_oe = 1, ad_out = latched address.
- GAP, for T_GAP cycles: control = 0111 (CS only), ad_oe = 0.
- DATA, for T_DATA cycles:
  - Write: control = 0110 (CS, WR asserted), ad_oe = 1, ad_out = latched wdata.
  - Read: control = 0101 (CS, RD asserted), ad_oe = 0. ad_in is captured into rdata on the last DATA cycle.
- REC, for T_REC cycles: control = 1111, ad_oe = 0. Then return to IDLE.
- The latched addr, wdata and we are fixed for the whole transaction. Changes on the inputs after grant are ignored.
- A req bit dropped after grant does not abort the transaction; done still pulses.
- A req bit dropped before grant is never serviced.
- Requesters deassert req in the cycle after done. If req is still high in that cycle, it counts as a new request.

## Timing
- Reset values: control 1111, ad_oe 0, ad_out 0, done 0, rdata 0, busy 0, state IDLE, round-robin pointer 1.
- Latency:
  - req seen in IDLE, to first ADDR cycle: 1 clock.
  - Full transaction: T_ADDR+T_GAP+T_DATA+T_REC cycles, which is 14 at default parameters.
- done:
  - Pulses for exactly one cycle, registered. It coincides with the first REC cycle.
  - The read rdata is valid in that same cycle.
- Next grant: the earliest next ADDR follows the last REC cycle by 1 IDLE cycle. There is no back-to-back transaction without an IDLE cycle.
- Simultaneous requests: index 0 wins. Among 1–3, the round-robin order decides.
- Reset asserted mid-transaction: all outputs and state return to their reset values immediately. No done pulse is issued, and the transaction is lost.
- ad_oe and the strobes change on the same edge. The GAP state guarantees bus turnaround before a read data phase.

## Structure
- The shared package rtc_pkg holds:
  - the state enum;
  - the control-vector constants CTRL_IDLE (1111), CTRL_ADDR_W (0010), CTRL_CS (0111), CTRL_WR (0110), CTRL_RD (0101);
  - the RTC register address constants used by the requesters.
- One sub-module, rtc_rr_arb: the combinational priority/round-robin grant plus its pointer register, parameterised on N_REQ.

## Test plan
- Single write: req[2]=1, we=1, addr=0x21, wdata=0x45.
  - Expect: ADDR with ad_out=0x21 and control 0010 for 4 cycles; 2 GAP cycles; DATA with ad_out=0x45 and control 0110 for 6 cycles.
  - Expect: done[2] pulses at cycle 13 after grant; busy spans 14 cycles.
- Single read: req[1]=1, we=0, addr=0x24, ad_in=0x17 held.
  - Expect: control 0101 and ad_oe=0 during DATA.
  - Expect: rdata=0x17 with done[1].
- Priority: req = 1111 asserted together.
  - Expect grant order 0, 1, 2, 3, one IDLE cycle between transactions, each done pulsing exactly once.
- Round-robin fairness: req[1] and req[3] held high continuously, each requester re-requesting after its done.
  - Expect grants alternating 1, 3, 1, 3 over 4 transactions.
- Reset mid-operation: drive reset low during DATA of a write.
  - Expect control=1111, ad_oe=0 and busy=0 asynchronously.
  - Expect no done pulse and state IDLE after release.
- Input stability: change addr[15:8] from 0x22 to 0x99 during ADDR.
  - Expect ad_out to stay 0x22 for the whole address phase.
